// File: rtl/tcam_rw_if.sv
// Request/result bundle for the TCAM: write/invalidate/clear controls, search handshake and
// match results.
interface tcam_rw_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_care;
  logic                  inv_en;
  logic                  clear_all;
  logic                  search_valid;
  logic [DATA_WIDTH-1:0] search_key;
  logic                  search_ready;
  logic                  clear_busy;
  logic                  match_valid;
  logic                  match_found;
  logic [ADDR_WIDTH-1:0] match_address;
  logic                  match_multi;
  logic [ADDR_WIDTH:0]   match_count;

  modport master (
    output wr_en, wr_addr, wr_data, wr_care, inv_en, clear_all, search_valid, search_key,
    input  search_ready, clear_busy, match_valid, match_found, match_address, match_multi,
           match_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_care, inv_en, clear_all, search_valid, search_key,
    output search_ready, clear_busy, match_valid, match_found, match_address, match_multi,
           match_count
  );
endinterface

// File: rtl/tcam_rw.sv
// Ternary CAM with per-entry care mask, two-stage search pipeline (compare, then priority
// encode) and a sequential clear engine that invalidates one entry per cycle.
module tcam_rw #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  tcam_rw_if.slave   bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_idx_q;
  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] care_q [DEPTH];

  logic                  idle;
  logic                  accept;
  logic [DEPTH-1:0]      hit;

  logic                  s1_valid_q;
  logic [DEPTH-1:0]      s1_hit_q;
  logic [ADDR_WIDTH-1:0] enc_addr;
  logic [ADDR_WIDTH:0]   enc_count;

  logic                  mv_q;
  logic                  found_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  multi_q;
  logic [ADDR_WIDTH:0]   count_q;

  assign idle   = (state_q == StIdle);
  assign accept = bus.search_valid && idle;

  // Compare uses the contents before this edge's write, so a same-cycle write is not seen.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit[i] = valid_q[i] && (((bus.search_key ^ data_q[i]) & care_q[i]) == '0);
    end
  end

  // Pattern storage needs no reset; only the valid bits define visibility.
  always_ff @(posedge clk) begin
    if (idle && bus.wr_en) begin
      data_q[bus.wr_addr] <= bus.wr_data;
      care_q[bus.wr_addr] <= bus.wr_care;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      state_q   <= StIdle;
      clr_idx_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.wr_en)  valid_q[bus.wr_addr] <= 1'b1;
          // Later assignment wins: invalidate beats a same-address write.
          if (bus.inv_en) valid_q[bus.wr_addr] <= 1'b0;
          if (bus.clear_all) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
          end
        end
        StClear: begin
          valid_q[clr_idx_q] <= 1'b0;
          clr_idx_q          <= clr_idx_q + 1'b1;
          if (clr_idx_q == ADDR_WIDTH'(DEPTH - 1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_hit_q   <= hit;
    end
  end

  always_comb begin
    enc_addr  = '0;
    enc_count = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) enc_addr = ADDR_WIDTH'(i);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      enc_count = enc_count + {{ADDR_WIDTH{1'b0}}, s1_hit_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv_q    <= 1'b0;
      found_q <= 1'b0;
      addr_q  <= '0;
      multi_q <= 1'b0;
      count_q <= '0;
    end else begin
      mv_q <= s1_valid_q;
      if (s1_valid_q) begin
        found_q <= |s1_hit_q;
        addr_q  <= enc_addr;
        multi_q <= (enc_count > (ADDR_WIDTH + 1)'(1));
        count_q <= enc_count;
      end
    end
  end

  assign bus.search_ready  = idle;
  assign bus.clear_busy    = (state_q == StClear);
  assign bus.match_valid   = mv_q;
  assign bus.match_found   = found_q;
  assign bus.match_address = addr_q;
  assign bus.match_multi   = multi_q;
  assign bus.match_count   = count_q;
endmodule

// File: tb/tb_tcam_rw.sv
// Directed bench for tcam_rw: each task drives one scenario and checks hand-computed results.
module tb_tcam_rw;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  tcam_rw_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  tcam_rw #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [15:0] d, input logic [15:0] c);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_care = c;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic inv_entry(input logic [3:0] a);
    bus.inv_en = 1'b1; bus.wr_addr = a;
    tick();
    bus.inv_en = 1'b0;
  endtask

  // Drives one search and waits (bounded) for its result; lat = edges after the accept edge.
  task automatic run_search(input logic [15:0] key, output logic seen, output int lat);
    bus.search_valid = 1'b1; bus.search_key = key;
    tick();
    bus.search_valid = 1'b0;
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 4 && !seen; i++) begin
      tick();
      if (bus.match_valid) begin seen = 1'b1; lat = i; end
    end
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_care = 0; bus.inv_en = 0;
    bus.clear_all = 0; bus.search_valid = 0; bus.search_key = 0;
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if (bus.match_valid !== 1'b0 || bus.match_found !== 1'b0 || bus.match_address !== 4'd0 ||
        bus.match_multi !== 1'b0 || bus.match_count !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_results: got mv=%b f=%b a=%0d m=%b c=%0d, expected all 0",
               bus.match_valid, bus.match_found, bus.match_address, bus.match_multi,
               bus.match_count);
    end
    vectors++;
    if (bus.search_ready !== 1'b1 || bus.clear_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: got ready=%b busy=%b, expected ready=1 busy=0",
               bus.search_ready, bus.clear_busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_empty_search();
    logic seen; int lat;
    run_search(16'hFFFF, seen, lat);
    vectors++;
    if (!seen || lat != 1) begin
      miscompares++;
      $display("FAIL empty_latency: got seen=%b lat=%0d, expected seen=1 lat=1", seen, lat);
    end
    vectors++;
    if (bus.match_found !== 1'b0 || bus.match_count !== 5'd0 || bus.match_address !== 4'd0) begin
      miscompares++;
      $display("FAIL empty_result: got f=%b c=%0d a=%0d, expected f=0 c=0 a=0",
               bus.match_found, bus.match_count, bus.match_address);
    end
    tick();
    vectors++;
    if (bus.match_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_pulse_width: got mv=%b, expected 0", bus.match_valid);
    end
  endtask

  task automatic test_match();
    logic seen; int lat;
    write_entry(4'd3, 16'h9249, 16'hFFFF);
    write_entry(4'd7, 16'h0000, 16'h0000);
    run_search(16'h9249, seen, lat);
    vectors++;
    if (!seen || bus.match_found !== 1'b1 || bus.match_address !== 4'd3 ||
        bus.match_multi !== 1'b1 || bus.match_count !== 5'd2) begin
      miscompares++;
      $display("FAIL match_9249: got seen=%b f=%b a=%0d m=%b c=%0d, expected 1 1 3 1 2",
               seen, bus.match_found, bus.match_address, bus.match_multi, bus.match_count);
    end
    tick();
    vectors++;
    if (bus.match_valid !== 1'b0 || bus.match_address !== 4'd3 || bus.match_count !== 5'd2) begin
      miscompares++;
      $display("FAIL match_hold: got mv=%b a=%0d c=%0d, expected mv=0 a=3 c=2",
               bus.match_valid, bus.match_address, bus.match_count);
    end
    run_search(16'h5A5A, seen, lat);
    vectors++;
    if (!seen || bus.match_found !== 1'b1 || bus.match_address !== 4'd7 ||
        bus.match_multi !== 1'b0 || bus.match_count !== 5'd1) begin
      miscompares++;
      $display("FAIL match_5a5a: got seen=%b f=%b a=%0d m=%b c=%0d, expected 1 1 7 0 1",
               seen, bus.match_found, bus.match_address, bus.match_multi, bus.match_count);
    end
  endtask

  task automatic test_write_search_same_cycle();
    logic seen; int lat;
    inv_entry(4'd7);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'hFC00; bus.wr_care = 16'hFF00;
    run_search(16'hFCCC, seen, lat);
    bus.wr_en = 1'b0;
    vectors++;
    if (!seen || bus.match_found !== 1'b0 || bus.match_count !== 5'd0) begin
      miscompares++;
      $display("FAIL same_cycle_pre_write: got seen=%b f=%b c=%0d, expected 1 0 0",
               seen, bus.match_found, bus.match_count);
    end
    run_search(16'hFCCC, seen, lat);
    vectors++;
    if (!seen || bus.match_found !== 1'b1 || bus.match_address !== 4'd2 ||
        bus.match_count !== 5'd1 || bus.match_multi !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle_post_write: got seen=%b f=%b a=%0d c=%0d m=%b, expected 1 1 2 1 0",
               seen, bus.match_found, bus.match_address, bus.match_count, bus.match_multi);
    end
  endtask

  task automatic test_back_to_back();
    inv_entry(4'd2);
    bus.search_valid = 1'b1; bus.search_key = 16'h9249;
    tick();
    bus.search_key = 16'h1111;
    tick();
    vectors++;
    if (bus.match_valid !== 1'b1 || bus.match_found !== 1'b1 || bus.match_address !== 4'd3) begin
      miscompares++;
      $display("FAIL b2b_first: got mv=%b f=%b a=%0d, expected 1 1 3",
               bus.match_valid, bus.match_found, bus.match_address);
    end
    bus.search_key = 16'h9249;
    tick();
    bus.search_valid = 1'b0;
    vectors++;
    if (bus.match_valid !== 1'b1 || bus.match_found !== 1'b0 || bus.match_count !== 5'd0) begin
      miscompares++;
      $display("FAIL b2b_second: got mv=%b f=%b c=%0d, expected 1 0 0",
               bus.match_valid, bus.match_found, bus.match_count);
    end
    tick();
    vectors++;
    if (bus.match_valid !== 1'b1 || bus.match_found !== 1'b1 || bus.match_count !== 5'd1) begin
      miscompares++;
      $display("FAIL b2b_third: got mv=%b f=%b c=%0d, expected 1 1 1",
               bus.match_valid, bus.match_found, bus.match_count);
    end
    tick();
    vectors++;
    if (bus.match_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got mv=%b, expected 0", bus.match_valid);
    end
  endtask

  task automatic test_clear();
    int busy = 0; int pulses = 0; int bad_ready = 0;
    logic seen; int lat;
    bus.clear_all = 1'b1;
    tick();
    bus.clear_all = 1'b0;
    for (int i = 0; i < 22; i++) begin
      // Ignored requests while clearing: a search and a write that would re-validate e5.
      bus.search_valid = (i < 10); bus.search_key = 16'h9249;
      bus.wr_en = (i < 10); bus.wr_addr = 4'd5; bus.wr_data = 16'h9249; bus.wr_care = 16'hFFFF;
      if (bus.clear_busy) busy++;
      if (bus.match_valid) pulses++;
      if (bus.search_ready === bus.clear_busy) bad_ready++;
      tick();
    end
    bus.search_valid = 1'b0; bus.wr_en = 1'b0;
    vectors++;
    if (busy != 16 || bad_ready != 0) begin
      miscompares++;
      $display("FAIL clear_window: got busy=%0d bad_ready=%0d, expected 16 0", busy, bad_ready);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL clear_no_pulse: got %0d pulses, expected 0", pulses);
    end
    run_search(16'h9249, seen, lat);
    vectors++;
    if (!seen || bus.match_found !== 1'b0 || bus.match_count !== 5'd0) begin
      miscompares++;
      $display("FAIL clear_after: got seen=%b f=%b c=%0d, expected 1 0 0",
               seen, bus.match_found, bus.match_count);
    end
  endtask

  task automatic test_clear_reset();
    logic seen; int lat;
    write_entry(4'd3, 16'h9249, 16'hFFFF);
    write_entry(4'd10, 16'hABCD, 16'hFFFF);
    bus.clear_all = 1'b1;
    tick();
    bus.clear_all = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.search_ready !== 1'b1 || bus.clear_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_rst_status: got ready=%b busy=%b, expected 1 0",
               bus.search_ready, bus.clear_busy);
    end
    run_search(16'hABCD, seen, lat);
    vectors++;
    if (!seen || bus.match_found !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_rst_e10: got seen=%b f=%b, expected 1 0", seen, bus.match_found);
    end
    run_search(16'h9249, seen, lat);
    vectors++;
    if (!seen || bus.match_found !== 1'b0 || bus.clear_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_rst_e3: got seen=%b f=%b busy=%b, expected 1 0 0",
               seen, bus.match_found, bus.clear_busy);
    end
  endtask

  task automatic test_reset_pipeline();
    int pulses = 0;
    write_entry(4'd7, 16'h0000, 16'h0000);
    bus.search_valid = 1'b1; bus.search_key = 16'h1234;
    tick();
    bus.search_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.match_valid) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 0 || bus.match_found !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pipeline: got pulses=%0d f=%b, expected 0 0", pulses, bus.match_found);
    end
  endtask

  task automatic test_wr_inv_collision();
    logic seen; int lat;
    bus.wr_en = 1'b1; bus.inv_en = 1'b1;
    bus.wr_addr = 4'd7; bus.wr_data = 16'h0000; bus.wr_care = 16'h0000;
    tick();
    bus.wr_en = 1'b0; bus.inv_en = 1'b0;
    run_search(16'h0000, seen, lat);
    vectors++;
    if (!seen || bus.match_found !== 1'b0 || bus.match_count !== 5'd0) begin
      miscompares++;
      $display("FAIL wr_inv_collision: got seen=%b f=%b c=%0d, expected 1 0 0",
               seen, bus.match_found, bus.match_count);
    end
  endtask

  task automatic test_clear_with_search();
    int waited = 0;
    logic seen; int lat;
    write_entry(4'd3, 16'h9249, 16'hFFFF);
    bus.clear_all = 1'b1; bus.search_valid = 1'b1; bus.search_key = 16'h9249;
    tick();
    bus.clear_all = 1'b0; bus.search_valid = 1'b0;
    vectors++;
    if (bus.clear_busy !== 1'b1 || bus.search_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_srch_state: got busy=%b ready=%b, expected 1 0",
               bus.clear_busy, bus.search_ready);
    end
    tick();
    vectors++;
    if (bus.match_valid !== 1'b1 || bus.match_found !== 1'b1 || bus.match_address !== 4'd3) begin
      miscompares++;
      $display("FAIL clr_srch_result: got mv=%b f=%b a=%0d, expected 1 1 3",
               bus.match_valid, bus.match_found, bus.match_address);
    end
    while (bus.clear_busy && waited < 40) begin
      tick();
      waited++;
    end
    vectors++;
    if (bus.clear_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_srch_timeout: got busy=%b after %0d cycles, expected 0",
               bus.clear_busy, waited);
    end
    run_search(16'h9249, seen, lat);
    vectors++;
    if (!seen || bus.match_found !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_srch_after: got seen=%b f=%b, expected 1 0", seen, bus.match_found);
    end
  endtask

  initial begin
    test_reset();
    test_empty_search();
    test_match();
    test_write_search_same_cycle();
    test_back_to_back();
    test_clear();
    test_clear_reset();
    test_reset_pipeline();
    test_wr_inv_collision();
    test_clear_with_search();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
